// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter sequencer: state encodings, default widths
// and the command decoder used by the control FSM.
package counter_ctrl_pkg;

    localparam int CC_WIDTH   = 8;
    localparam int CC_PRESC_W = 4;

    localparam logic [1:0] CC_IDLE = 2'd0;
    localparam logic [1:0] CC_LOAD = 2'd1;
    localparam logic [1:0] CC_RUN  = 2'd2;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_START = 2'd1,
        CMD_STOP  = 2'd2,
        CMD_CLR   = 2'd3
    } cmd_e;

    // Clear beats stop beats start when several arrive together.
    function automatic cmd_e cmd_decode(input logic start, input logic stop, input logic clr);
        cmd_e c;
        if (clr)        c = CMD_CLR;
        else if (stop)  c = CMD_STOP;
        else if (start) c = CMD_START;
        else            c = CMD_NONE;
        return c;
    endfunction

endpackage

// File: rtl/counter.sv
// Plain wrapping up-counter with clear, parallel load and enable (clr > we > en).
// Lives beside counter_ctrl at the parent level.
module counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic [WIDTH-1:0] dat_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)     dat_o <= '0;
        else if (clr_i)  dat_o <= '0;
        else if (we_i)   dat_o <= dat_i;
        else if (en_i)   dat_o <= dat_o + 1'b1;
    end

endmodule

// File: rtl/counter_ctrl_presc.sv
// Prescaler: fires once every presc+1 cycles while running; clear forces it back to 0.
module counter_ctrl_presc #(
    parameter int PRESC_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear,
    input  logic               run,
    input  logic [PRESC_W-1:0] presc,
    output logic               fire
);

    logic [PRESC_W-1:0] cnt;

    assign fire = run && (cnt == presc);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      cnt <= '0;
        else if (clear)   cnt <= '0;
        else if (run)     cnt <= fire ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/counter_ctrl.sv
// Programmable timer sequencer: drives one external counter's clr/en/we strobes,
// paces increments with a prescaler, detects the match value and raises tick/irq.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH   = CC_WIDTH,
    parameter int PRESC_W = CC_PRESC_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               clr_i,
    input  logic               periodic_i,
    input  logic [WIDTH-1:0]   load_val_i,
    input  logic [WIDTH-1:0]   match_val_i,
    input  logic [PRESC_W-1:0] presc_i,
    input  logic               irq_ack_i,
    input  logic [WIDTH-1:0]   cnt_dat_i,
    output logic               cnt_clr_o,
    output logic               cnt_en_o,
    output logic               cnt_we_o,
    output logic [WIDTH-1:0]   cnt_dat_o,
    output logic               busy_o,
    output logic               tick_o,
    output logic               irq_o
);

    logic [1:0]         state, state_nxt;
    logic [WIDTH-1:0]   load_val, match_val;
    logic [PRESC_W-1:0] presc;
    logic               periodic;

    cmd_e cmd;
    logic match, fire, presc_clear, latch;
    logic clr_s, en_s, we_s, tick_s;

    assign cmd   = cmd_decode(start_i, stop_i, clr_i);
    assign match = (cnt_dat_i == match_val);

    counter_ctrl_presc #(.PRESC_W(PRESC_W)) u_presc (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clear (presc_clear),
        .run   (state == CC_RUN),
        .presc (presc),
        .fire  (fire)
    );

    always_comb begin
        state_nxt   = state;
        clr_s       = 1'b0;
        en_s        = 1'b0;
        we_s        = 1'b0;
        tick_s      = 1'b0;
        latch       = 1'b0;
        presc_clear = 1'b1;
        case (state)
            CC_IDLE: begin
                case (cmd)
                    CMD_CLR:   clr_s = 1'b1;
                    CMD_START: begin
                        latch     = 1'b1;
                        state_nxt = CC_LOAD;
                    end
                    default: ;
                endcase
            end
            CC_LOAD: begin
                case (cmd)
                    CMD_CLR: begin
                        clr_s     = 1'b1;
                        state_nxt = CC_IDLE;
                    end
                    CMD_STOP:  state_nxt = CC_IDLE;
                    // Re-latch and write the fresh load value on the next LOAD cycle.
                    CMD_START: latch = 1'b1;
                    default: begin
                        we_s      = 1'b1;
                        state_nxt = CC_RUN;
                    end
                endcase
            end
            CC_RUN: begin
                case (cmd)
                    CMD_CLR: begin
                        clr_s     = 1'b1;
                        state_nxt = CC_IDLE;
                    end
                    CMD_STOP:  state_nxt = CC_IDLE;
                    CMD_START: begin
                        latch     = 1'b1;
                        state_nxt = CC_LOAD;
                    end
                    default: begin
                        if (match) begin
                            tick_s = 1'b1;
                            // Auto-reload writes L in the match cycle so spacing is 1 + D*(P+1).
                            if (periodic) we_s      = 1'b1;
                            else          state_nxt = CC_IDLE;
                        end else begin
                            presc_clear = 1'b0;
                            en_s        = fire;
                        end
                    end
                endcase
            end
            default: state_nxt = CC_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= CC_IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            load_val  <= '0;
            match_val <= '0;
            presc     <= '0;
            periodic  <= 1'b0;
        end else if (latch) begin
            load_val  <= load_val_i;
            match_val <= match_val_i;
            presc     <= presc_i;
            periodic  <= periodic_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)        irq_o <= 1'b0;
        else if (tick_s)    irq_o <= 1'b1;
        else if (irq_ack_i) irq_o <= 1'b0;
    end

    // IDLE passes clr_i straight through, so hold it off while reset is asserted.
    assign cnt_clr_o = clr_s & rst_ni;
    assign cnt_en_o  = en_s;
    assign cnt_we_o  = we_s;
    assign cnt_dat_o = load_val;
    assign tick_o    = tick_s;
    assign busy_o    = (state == CC_LOAD) || (state == CC_RUN);

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl driving a real counter; expectations are queued with
// their target cycle when stimulus is applied and compared on the falling edge.
module tb_counter_ctrl;
    import counter_ctrl_pkg::*;

    localparam int W  = 8;
    localparam int PW = 4;

    localparam int S_TICK = 0, S_CNT = 1, S_BUSY = 2, S_IRQ = 3,
                   S_WE = 4, S_CLR = 5, S_EN = 6, S_WDAT = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, stop = 1'b0, clr = 1'b0, periodic = 1'b0, irq_ack = 1'b0;
    logic [W-1:0]  load_val = '0, match_val = '0;
    logic [PW-1:0] presc = '0;
    logic [W-1:0]  cnt_q, cnt_wdat;
    logic          cnt_clr, cnt_en, cnt_we, busy, tick, irq;

    counter_ctrl #(.WIDTH(W), .PRESC_W(PW)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .stop_i     (stop),
        .clr_i      (clr),
        .periodic_i (periodic),
        .load_val_i (load_val),
        .match_val_i(match_val),
        .presc_i    (presc),
        .irq_ack_i  (irq_ack),
        .cnt_dat_i  (cnt_q),
        .cnt_clr_o  (cnt_clr),
        .cnt_en_o   (cnt_en),
        .cnt_we_o   (cnt_we),
        .cnt_dat_o  (cnt_wdat),
        .busy_o     (busy),
        .tick_o     (tick),
        .irq_o      (irq)
    );

    counter #(.WIDTH(W)) u_cnt (
        .clk_i (clk),
        .rst_ni(rst_n),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .we_i  (cnt_we),
        .dat_i (cnt_wdat),
        .dat_o (cnt_q)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0, n_err = 0, tick_cnt = 0;

    typedef struct {
        int unsigned at;
        int          sig;
        logic [31:0] val;
        string       tag;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic logic [31:0] probe(input int sig);
        case (sig)
            S_TICK:  return {31'd0, tick};
            S_CNT:   return {24'd0, cnt_q};
            S_BUSY:  return {31'd0, busy};
            S_IRQ:   return {31'd0, irq};
            S_WE:    return {31'd0, cnt_we};
            S_CLR:   return {31'd0, cnt_clr};
            S_EN:    return {31'd0, cnt_en};
            default: return {24'd0, cnt_wdat};
        endcase
    endfunction

    task automatic push(input int unsigned at, input int sig, input logic [31:0] val, input string tag);
        exp_t e;
        int   i;
        e.at = at; e.sig = sig; e.val = val; e.tag = tag;
        i = 0;
        while (i < sb.size() && sb[i].at <= at) i++;
        sb.insert(i, e);
    endtask

    always @(negedge clk) begin
        if (tick === 1'b1) tick_cnt <= tick_cnt + 1;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.tag, probe(e.sig), e.val);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // 0 start, 1 stop, 2 clr, 3 irq_ack; held for one cycle.
    task automatic pulse(input int which);
        case (which)
            0: start = 1'b1;
            1: stop = 1'b1;
            2: clr = 1'b1;
            default: irq_ack = 1'b1;
        endcase
        step(1);
        start = 1'b0; stop = 1'b0; clr = 1'b0; irq_ack = 1'b0;
    endtask

    task automatic cfg(input logic per, input logic [W-1:0] l, input logic [W-1:0] m, input logic [PW-1:0] p);
        periodic = per; load_val = l; match_val = m; presc = p;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned s, c;
        int t0;

        step(2);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_tick", {31'd0, tick}, 0);
        chk("rst_irq", {31'd0, irq}, 0);
        chk("rst_strobes", {29'd0, cnt_clr, cnt_en, cnt_we}, 0);
        chk("rst_wdat", {24'd0, cnt_wdat}, 0);
        rst_n = 1'b1;
        step(2);

        // One-shot L=10 M=14 P=0: tick 6 cycles after start.
        cfg(1'b0, 8'h10, 8'h14, 4'd0);
        s = cyc;
        push(s + 1, S_BUSY, 1, "os_busy_load");
        push(s + 1, S_WE, 1, "os_we_load");
        push(s + 2, S_CNT, 8'h10, "os_first");
        push(s + 5, S_TICK, 0, "os_early");
        push(s + 6, S_TICK, 1, "os_tick");
        push(s + 6, S_CNT, 8'h14, "os_cnt_match");
        push(s + 7, S_TICK, 0, "os_tick_pulse");
        push(s + 7, S_BUSY, 0, "os_busy_fall");
        push(s + 7, S_IRQ, 1, "os_irq");
        push(s + 15, S_CNT, 8'h14, "os_hold");
        push(s + 15, S_IRQ, 1, "os_irq_sticky");
        t0 = tick_cnt;
        pulse(0);
        step(20);
        chk("os_tick_count", tick_cnt - t0, 1);
        s = cyc;
        push(s + 1, S_IRQ, 0, "os_irq_ack");
        pulse(3);
        step(2);

        // Periodic L=A5 M=A8 P=2: ticks every 10 cycles.
        cfg(1'b1, 8'hA5, 8'hA8, 4'd2);
        s = cyc;
        push(s + 10, S_TICK, 0, "per_pre");
        push(s + 11, S_TICK, 1, "per_tick1");
        push(s + 11, S_CNT, 8'hA8, "per_cnt_m");
        push(s + 12, S_CNT, 8'hA5, "per_reload");
        push(s + 14, S_CNT, 8'hA5, "per_presc_hold");
        push(s + 15, S_CNT, 8'hA6, "per_step");
        push(s + 20, S_TICK, 0, "per_gap");
        push(s + 21, S_TICK, 1, "per_tick2");
        push(s + 22, S_TICK, 0, "per_gap2");
        push(s + 31, S_TICK, 1, "per_tick3");
        push(s + 36, S_BUSY, 0, "per_stopped");
        t0 = tick_cnt;
        pulse(0);
        step(34);
        pulse(1);
        step(1);
        chk("per_tick_count", tick_cnt - t0, 3);
        pulse(3);
        step(1);

        // Wrap L=FE M=01: FE,FF,00,01, tick 5 cycles after start.
        cfg(1'b0, 8'hFE, 8'h01, 4'd0);
        s = cyc;
        push(s + 2, S_CNT, 8'hFE, "wr_fe");
        push(s + 3, S_CNT, 8'hFF, "wr_ff");
        push(s + 4, S_CNT, 8'h00, "wr_00");
        push(s + 4, S_TICK, 0, "wr_early");
        push(s + 5, S_CNT, 8'h01, "wr_01");
        push(s + 5, S_TICK, 1, "wr_tick");
        push(s + 6, S_BUSY, 0, "wr_done");
        pulse(0);
        step(8);
        pulse(3);
        step(1);

        // Stop at 0x12, hold 300 cycles, then clear.
        cfg(1'b0, 8'h10, 8'h20, 4'd0);
        s = cyc;
        push(s + 4, S_CNT, 8'h12, "sc_at12");
        push(s + 5, S_CNT, 8'h12, "sc_frozen");
        push(s + 5, S_BUSY, 0, "sc_busy_stop");
        push(s + 305, S_CNT, 8'h12, "sc_frozen_300");
        pulse(0);
        step(3);
        pulse(1);
        t0 = tick_cnt;
        step(301);
        chk("sc_no_tick", tick_cnt - t0, 0);
        c = cyc;
        push(c, S_CLR, 1, "sc_clr_strobe");
        push(c + 1, S_CNT, 8'h00, "sc_cleared");
        push(c + 1, S_BUSY, 0, "sc_busy_clr");
        pulse(2);
        step(2);

        // M==L periodic: tick every RUN cycle; ack colliding with tick keeps irq.
        cfg(1'b1, 8'h33, 8'h33, 4'd3);
        s = cyc;
        for (int i = 2; i <= 8; i++) push(s + i, S_TICK, 1, "eq_tick");
        push(s + 8, S_IRQ, 1, "eq_ack_collide");
        pulse(0);
        step(6);
        pulse(3);
        step(1);
        pulse(1);
        c = cyc;
        push(c + 1, S_IRQ, 0, "eq_ack_clear");
        pulse(3);
        step(1);

        // start_i while running restarts with the new load value.
        cfg(1'b0, 8'h40, 8'h80, 4'd0);
        s = cyc;
        push(s + 5, S_CNT, 8'h43, "rs_before");
        push(s + 5, S_TICK, 0, "rs_no_tick");
        push(s + 6, S_WE, 1, "rs_we");
        push(s + 6, S_BUSY, 1, "rs_busy");
        push(s + 6, S_WDAT, 8'h60, "rs_wdat");
        push(s + 7, S_CNT, 8'h60, "rs_reloaded");
        push(s + 8, S_CNT, 8'h61, "rs_counting");
        pulse(0);
        step(4);
        load_val = 8'h60;
        pulse(0);
        step(4);
        pulse(1);
        step(1);

        // Async reset mid-run forces every output low at once.
        cfg(1'b1, 8'h77, 8'h77, 4'd0);
        pulse(0);
        step(4);
        #1;
        chk("rr_pre_tick", {31'd0, tick}, 1);
        chk("rr_pre_irq", {31'd0, irq}, 1);
        rst_n = 1'b0;
        #1;
        chk("rr_busy", {31'd0, busy}, 0);
        chk("rr_tick", {31'd0, tick}, 0);
        chk("rr_irq", {31'd0, irq}, 0);
        chk("rr_strobes", {29'd0, cnt_clr, cnt_en, cnt_we}, 0);
        chk("rr_wdat", {24'd0, cnt_wdat}, 0);
        step(2);
        rst_n = 1'b1;
        step(2);
        chk("rr_idle", {31'd0, busy}, 0);

        chk("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
